// File: rtl/serial_adder_8bit_if.sv
// rtl/serial_adder_8bit_if.sv - start/busy/done operand and result bundle for serial_adder_8bit (sub port with SUB_MODE_EN)
interface serial_adder_8bit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             busy;
  logic             done;
`ifdef SUB_MODE_EN
  logic             sub;
`endif

  modport master (
`ifdef SUB_MODE_EN
    output sub,
`endif
    output start, a, b,
    input  s, cout, busy, done
  );

  modport slave (
`ifdef SUB_MODE_EN
    input  sub,
`endif
    input  start, a, b,
    output s, cout, busy, done
  );
endinterface

// File: rtl/serial_adder_8bit.sv
// rtl/serial_adder_8bit.sv - bit-serial LSB-first adder, one bit per clock; SUB_MODE_EN adds a - b via the sub input
module serial_adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_8bit_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_res_next;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_in;
  logic             w_carry_in;

  // Full-adder slice on the current LSBs, and the operand conditioning applied at capture
  always_comb begin
    w_sum      = r_a[0] ^ r_b[0] ^ r_carry;
    w_carry    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    w_res_next = {w_sum, r_res[WIDTH-1:1]};
    w_accept   = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
`ifdef SUB_MODE_EN
    // Subtraction is a + ~b + 1: invert B and seed the carry
    w_b_in     = bus.sub ? ~bus.b : bus.b;
    w_carry_in = bus.sub;
`else
    w_b_in     = bus.b;
    w_carry_in = 1'b0;
`endif
  end

  // Control FSM and serial datapath; s/cout are only written when the last bit is produced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          r_res   <= w_res_next;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_carry;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) begin
            r_s     <= w_res_next;
            r_cout  <= w_carry;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE lasts exactly one cycle
          r_done <= 1'b0;
          if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= w_b_in;
            r_res   <= '0;
            r_carry <= w_carry_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.s    = r_s;
  assign bus.cout = r_cout;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule
